uart_tx_frame: RTL and testbench

// - Parametrised UART transmitter; next generation of the fixed 8-bit/parity-always TX.
// - Adds configurable data width, runtime parity mode (none/even/odd) and 1 or 2 stop bits.
// - Latches data and config on accept; adds a one-cycle done pulse.
// - Sits between the APB-side TX holding logic and the TX pad; the baud divisor comes from the shared WORK_FR register.

---
 rtl/uart_tx_frame.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter, LSB-first data, optional
// even/odd parity, one or two stop bits, one-cycle completion pulse.
// Optional feature macro: UART_TX_BREAK_EN adds BREAK_I and a break state.
// Ports:
//   PCLK, RESET  clock and synchronous active-high reset
//   DATA_TX_I    character to send (DATA_W bits), latched on accept
//   WORK_FR      bit time minus one in PCLK cycles, latched on accept
//   PARITY_MODE  00/11 none, 01 even, 10 odd, latched on accept
//   STOP2        1 selects two stop bits, latched on accept
//   START        level request, accepted only while READY_TX=1
//   BREAK_I      break request (UART_TX_BREAK_EN only)
//   TX_O         registered serial line, idle high
//   READY_TX     idle indicator
//   TX_DONE      pulse during the final cycle of the last stop bit
module uart_tx_frame #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 12
) (
   input  logic              PCLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] DATA_TX_I,
   input  logic [DIV_W-1:0]  WORK_FR,
   input  logic [1:0]        PARITY_MODE,
   input  logic              STOP2,
   input  logic              START,
`ifdef UART_TX_BREAK_EN
   input  logic              BREAK_I,
`endif
   output logic              TX_O,
   output logic              READY_TX,
   output logic              TX_DONE
);

   localparam int unsigned IDX_W = $clog2(DATA_W);

`ifdef UART_TX_BREAK_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3,
      S_STOP1 = 3'd4, S_STOP2 = 3'd5, S_BRK = 3'd6, S_BRK_IDLE = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3,
      S_STOP1 = 3'd4, S_STOP2 = 3'd5
   } state_t;
`endif

   state_t            state;
   logic [DIV_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] data_l;
   logic [DIV_W-1:0]  wfr_l;
   logic [1:0]        par_l;
   logic              stop2_l;

   logic              bit_end;
   logic              cnt_almost;
   logic              par_en;
   logic              par_bit;
   logic              last_stop;
   logic              wfr_zero;
   logic [IDX_W-1:0]  idx_nxt;

   // Bit-timing and frame-shape decodes from the latched configuration
   assign bit_end    = (cnt == wfr_l);
   assign cnt_almost = ((cnt + DIV_W'(1)) == wfr_l);
   assign wfr_zero   = (wfr_l == '0);
   assign par_en     = (par_l == 2'b01) || (par_l == 2'b10);
   assign par_bit    = par_l[1] ? ~^data_l : ^data_l;
   assign last_stop  = (state == S_STOP2) || ((state == S_STOP1) && !stop2_l);
   assign idx_nxt    = idx + IDX_W'(1);

   // Frame sequencer; TX_DONE is set one edge early so it lines up with the
   // final cycle of the last stop bit (entry-time set covers WORK_FR=0)
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         state    <= S_IDLE;
         cnt      <= '0;
         idx      <= '0;
         data_l   <= '0;
         wfr_l    <= '0;
         par_l    <= '0;
         stop2_l  <= 1'b0;
         TX_O     <= 1'b1;
         READY_TX <= 1'b1;
         TX_DONE  <= 1'b0;
      end else begin
         if (bit_end) cnt <= '0;
         else         cnt <= cnt + DIV_W'(1);
         TX_DONE <= last_stop && !bit_end && cnt_almost;

         case (state)
            S_IDLE: begin
               cnt      <= '0;
               idx      <= '0;
               TX_O     <= 1'b1;
               READY_TX <= 1'b1;
`ifdef UART_TX_BREAK_EN
               if (BREAK_I) begin
                  state    <= S_BRK;
                  TX_O     <= 1'b0;
                  READY_TX <= 1'b0;
               end else
`endif
               if (START) begin
                  state    <= S_START;
                  data_l   <= DATA_TX_I;
                  wfr_l    <= WORK_FR;
                  par_l    <= PARITY_MODE;
                  stop2_l  <= STOP2;
                  TX_O     <= 1'b0;
                  READY_TX <= 1'b0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  state <= S_DATA;
                  TX_O  <= data_l[0];
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (idx == IDX_W'(DATA_W - 1)) begin
                     idx <= '0;
                     if (par_en) begin
                        state <= S_PARITY;
                        TX_O  <= par_bit;
                     end else begin
                        state   <= S_STOP1;
                        TX_O    <= 1'b1;
                        TX_DONE <= wfr_zero && !stop2_l;
                     end
                  end else begin
                     idx  <= idx_nxt;
                     TX_O <= data_l[idx_nxt];
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  state   <= S_STOP1;
                  TX_O    <= 1'b1;
                  TX_DONE <= wfr_zero && !stop2_l;
               end
            end
            S_STOP1: begin
               if (bit_end) begin
                  if (stop2_l) begin
                     state   <= S_STOP2;
                     TX_DONE <= wfr_zero;
                  end else begin
                     state    <= S_IDLE;
                     READY_TX <= 1'b1;
                  end
               end
            end
            S_STOP2: begin
               if (bit_end) begin
                  state    <= S_IDLE;
                  READY_TX <= 1'b1;
               end
            end
`ifdef UART_TX_BREAK_EN
            S_BRK: begin
               cnt     <= '0;
               TX_DONE <= 1'b0;
               if (BREAK_I) begin
                  TX_O <= 1'b0;
               end else begin
                  // one idle bit time at the current divisor before re-arming
                  state <= S_BRK_IDLE;
                  wfr_l <= WORK_FR;
                  TX_O  <= 1'b1;
               end
            end
            S_BRK_IDLE: begin
               TX_DONE <= 1'b0;
               if (bit_end) begin
                  state    <= S_IDLE;
                  READY_TX <= 1'b1;
               end
            end
`endif
            default: begin
               state    <= S_IDLE;
               cnt      <= '0;
               idx      <= '0;
               TX_O     <= 1'b1;
               READY_TX <= 1'b1;
               TX_DONE  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame (8-bit and 5-bit
// instances). Expected waveforms come from a frame-level bit-list model.
module tb_uart_tx_frame;

   logic        PCLK;
   logic        RESET;
   logic [7:0]  DATA_TX_I;
   logic [11:0] WORK_FR;
   logic [1:0]  PARITY_MODE;
   logic        STOP2;
   logic        START;
   logic        TX_O;
   logic        READY_TX;
   logic        TX_DONE;

   logic [4:0]  d5;
   logic [11:0] wfr5;
   logic [1:0]  mode5;
   logic        s2_5;
   logic        start5;
   logic        tx5;
   logic        rdy5;
   logic        done5;

   int tests = 0;
   int fails = 0;
   bit exp_q[$];

   typedef struct {
      logic [7:0]  data;
      logic [11:0] wfr;
      logic [1:0]  mode;
      logic        s2;
      int          start_ctl;   // 0 drop after accept, 1 hold, 2 pulse mid-frame
      bit          scramble;
      int          exp_len;
   } vec_t;

   vec_t tbl[9];

   uart_tx_frame #(.DATA_W(8), .DIV_W(12)) dut8 (
      .PCLK(PCLK), .RESET(RESET), .DATA_TX_I(DATA_TX_I), .WORK_FR(WORK_FR),
      .PARITY_MODE(PARITY_MODE), .STOP2(STOP2), .START(START),
      .TX_O(TX_O), .READY_TX(READY_TX), .TX_DONE(TX_DONE));

   uart_tx_frame #(.DATA_W(5), .DIV_W(12)) dut5 (
      .PCLK(PCLK), .RESET(RESET), .DATA_TX_I(d5), .WORK_FR(wfr5),
      .PARITY_MODE(mode5), .STOP2(s2_5), .START(start5),
      .TX_O(tx5), .READY_TX(rdy5), .TX_DONE(done5));

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Frame as a list of bit values: start, data LSB first, parity, stops
   task automatic build_frame(input logic [7:0] d, input logic [1:0] m, input logic s2);
      int ones;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
      ones = $countones(d);
      if (m == 2'b01) exp_q.push_back((ones % 2) == 1);
      if (m == 2'b10) exp_q.push_back((ones % 2) == 0);
      exp_q.push_back(1'b1);
      if (s2) exp_q.push_back(1'b1);
   endtask

   // Starts at a negedge with the DUT idle, ends at the negedge of the
   // READY_TX cycle following the frame
   task automatic run_frame(input vec_t v);
      int   w1, n, bad_n;
      bit   got_done;
      logic exp_tx, bad_tx, bad_exp;
      w1 = int'(v.wfr) + 1;
      build_frame(v.data, v.mode, v.s2);
      check("ready_pre", 32'(READY_TX), 32'd1);
      DATA_TX_I   = v.data;
      WORK_FR     = v.wfr;
      PARITY_MODE = v.mode;
      STOP2       = v.s2;
      START       = 1'b1;
      @(negedge PCLK);
      if (v.start_ctl != 1) START = 1'b0;
      if (v.scramble) begin
         DATA_TX_I   = 8'($urandom);
         WORK_FR     = 12'($urandom_range(0, 15));
         PARITY_MODE = 2'($urandom);
         STOP2       = 1'($urandom);
      end
      n = 0; got_done = 1'b0; bad_n = -1;
      bad_tx = 1'b0; bad_exp = 1'b0;
      while (!got_done && n < 300) begin
         if (v.start_ctl == 2) START = (n == 2 || n == 3);
         exp_tx = ((n / w1) < exp_q.size()) ? exp_q[n / w1] : 1'b1;
         if (bad_n < 0 && (TX_O !== exp_tx || READY_TX !== 1'b0)) begin
            bad_n = n; bad_tx = TX_O; bad_exp = exp_tx;
         end
         if (TX_DONE === 1'b1) got_done = 1'b1;
         n++;
         @(negedge PCLK);
      end
      check("frame_len", 32'(n), 32'(v.exp_len));
      tests++;
      if (bad_n >= 0) begin
         fails++;
         $display("FAIL wave: cycle %0d TX_O %b required %b (READY_TX %b)",
                  bad_n, bad_tx, bad_exp, READY_TX);
      end
      check("idle_ready", 32'(READY_TX), 32'd1);
      check("idle_done", 32'(TX_DONE), 32'd0);
      check("idle_tx", 32'(TX_O), 32'd1);
   endtask

   initial begin
      logic e5[9];
      vec_t rv;
      int   p;

      tbl[0] = '{8'hA5, 12'd3, 2'b00, 1'b0, 0, 1'b0, 40};
      tbl[1] = '{8'h07, 12'd3, 2'b01, 1'b0, 0, 1'b0, 44};
      tbl[2] = '{8'h07, 12'd3, 2'b10, 1'b0, 0, 1'b0, 44};
      tbl[3] = '{8'h07, 12'd3, 2'b11, 1'b0, 0, 1'b0, 40};
      tbl[4] = '{8'h3C, 12'd0, 2'b01, 1'b1, 0, 1'b0, 12};
      tbl[5] = '{8'hFF, 12'd1, 2'b10, 1'b1, 2, 1'b0, 24};
      tbl[6] = '{8'h00, 12'd2, 2'b00, 1'b1, 0, 1'b0, 33};
      tbl[7] = '{8'hA5, 12'd3, 2'b00, 1'b0, 1, 1'b1, 40};
      tbl[8] = '{8'h07, 12'd3, 2'b01, 1'b0, 0, 1'b0, 44};

      RESET = 1'b1; START = 1'b0; DATA_TX_I = '0; WORK_FR = '0;
      PARITY_MODE = '0; STOP2 = 1'b0;
      start5 = 1'b0; d5 = '0; wfr5 = '0; mode5 = '0; s2_5 = 1'b0;
      repeat (2) @(negedge PCLK);
      check("rst_tx", 32'(TX_O), 32'd1);
      check("rst_ready", 32'(READY_TX), 32'd1);
      check("rst_done", 32'(TX_DONE), 32'd0);
      check("rst5_tx", 32'(tx5), 32'd1);
      check("rst5_ready", 32'(rdy5), 32'd1);
      RESET = 1'b0;
      @(negedge PCLK);

      // 5-bit, odd parity, two stop bits, one cycle per bit
      e5 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      check("w5_ready_pre", 32'(rdy5), 32'd1);
      d5 = 5'h1F; wfr5 = 12'd0; mode5 = 2'b10; s2_5 = 1'b1; start5 = 1'b1;
      @(negedge PCLK);
      start5 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("w5_tx[%0d]", i), 32'(tx5), 32'(e5[i]));
         check($sformatf("w5_done[%0d]", i), 32'(done5), (i == 8) ? 32'd1 : 32'd0);
         @(negedge PCLK);
      end
      check("w5_ready_post", 32'(rdy5), 32'd1);

      // reset in the middle of the data bits
      DATA_TX_I = 8'h5A; WORK_FR = 12'd3; PARITY_MODE = 2'b01; STOP2 = 1'b1;
      START = 1'b1;
      @(negedge PCLK);
      START = 1'b0;
      repeat (10) @(negedge PCLK);
      check("mid_busy", 32'(READY_TX), 32'd0);
      RESET = 1'b1;
      @(negedge PCLK);
      check("mid_rst_tx", 32'(TX_O), 32'd1);
      check("mid_rst_ready", 32'(READY_TX), 32'd1);
      check("mid_rst_done", 32'(TX_DONE), 32'd0);
      RESET = 1'b0;
      @(negedge PCLK);
      check("mid_rst_idle", 32'(READY_TX), 32'd1);

      for (int k = 0; k < 9; k++) begin
         run_frame(tbl[k]);
         if (tbl[k].start_ctl == 2) begin
            @(negedge PCLK);
            check("no_queue_ready", 32'(READY_TX), 32'd1);
            check("no_queue_tx", 32'(TX_O), 32'd1);
         end
      end
      START = 1'b0;
      @(negedge PCLK);

      for (int k = 0; k < 12; k++) begin
         rv.data      = 8'($urandom);
         rv.wfr       = 12'($urandom_range(0, 4));
         rv.mode      = 2'($urandom);
         rv.s2        = 1'($urandom);
         rv.start_ctl = 0;
         rv.scramble  = 1'($urandom_range(0, 1));
         p = (rv.mode == 2'b01 || rv.mode == 2'b10) ? 1 : 0;
         rv.exp_len   = (1 + 8 + p + 1 + int'(rv.s2)) * (int'(rv.wfr) + 1);
         run_frame(rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
